serial_addsub: RTL and testbench

Bit-serial two's-complement add/subtract unit. It accepts two WIDTH-bit operands and an operation over a valid/ready handshake, then processes one bit per clock, LSB first, through a single `full_adder` cell with a registered carry. It returns the result and flags over a second valid/ready handshake. It serves area-constrained datapaths where one ripple cell plus shift registers replaces a WIDTH-bit parallel adder/subtractor.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub_full_adder.sv | 11 +
 rtl/serial_addsub.sv | 97 +++++++++
 tb/tb_serial_addsub.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response handshake bundle for serial_addsub.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/serial_addsub_full_adder.sv
// Single-bit full adder cell used by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract: one full_adder, LSB first, one bit per clock.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    import serial_addsub_pkg::*;

    localparam int unsigned   CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    addsub_state_t    state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             cy;
    logic             msb_cin;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (cy),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // A doubles as the result shift register: sum bits enter at the MSB as operand bits leave.
    assign sum_next = {fa_sum, a_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            cy         <= 1'b0;
            msb_cin    <= 1'b0;
            cnt        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        cy    <= bus.op;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= sum_next;
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    cy   <= fa_cout;
                    if (cnt == PENULT) begin
                        msb_cin <= fa_cout;
                    end
                    if (cnt == LAST) begin
                        result_q   <= sum_next;
                        carry_q    <= fa_cout;
                        overflow_q <= msb_cin ^ fa_cout;
                        zero_q     <= ~|sum_next;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and back-to-back checks for serial_addsub at WIDTH=8.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {zero, overflow, carry, result} from plain integer arithmetic.
    function automatic logic [10:0] model(input logic o, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] bb;
        logic [8:0] s;
        logic       ov;
        bb = o ? ~y : y;
        s  = {1'b0, x} + {1'b0, bb} + {8'd0, o};
        ov = (x[7] == bb[7]) && (s[7] != x[7]);
        return {(s[7:0] == 8'd0), ov, s[8], s[7:0]};
    endfunction

    // Called #1 after a rising edge with the unit idle; returns outputs seen in DONE.
    task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                          input logic release_out,
                          output logic [7:0] r, output logic c, output logic ov,
                          output logic z, output int lat);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = ~x;
        bus.b        = ~y;
        bus.op       = ~o;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r  = bus.result;
        c  = bus.carry;
        ov = bus.overflow;
        z  = bus.zero;
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic directed(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] er, input logic ec, input logic eov, input logic ez);
        logic [7:0] r;
        logic       c, ov, z;
        int         lat;
        run_op(o, x, y, 1'b1, r, c, ov, z, lat);
        check({tag, "_lat"}, lat, W);
        check({tag, "_res"}, r, er);
        check({tag, "_carry"}, c, ec);
        check({tag, "_ovf"}, ov, eov);
        check({tag, "_zero"}, z, ez);
        check({tag, "_idle"}, bus.in_ready, 1'b1);
    endtask

    logic [10:0] expq[$];

    initial begin
        logic [7:0] r;
        logic       c, ov, z;
        int         lat;
        int         accepts, results, last_acc;
        logic       acc;
        logic [10:0] e;

        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = 1'b0;
        bus.a = '0;
        bus.b = '0;

        #12;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 8'h00);
        check("rst_flags", {bus.carry, bus.overflow, bus.zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("add_basic", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0);
        directed("add_carry", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",   1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        directed("sub_borrow",1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",   1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        directed("sub_zero",  1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1);

        // Backpressure: hold DONE while new requests are offered.
        run_op(1'b1, 8'h80, 8'h01, 1'b0, r, c, ov, z, lat);
        check("bp_lat", lat, W);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0] ? 1'b0 : 1'b1;
            bus.op = 1'b0;
            bus.a = 8'(i * 17 + 3);
            bus.b = 8'(i * 29 + 5);
            @(posedge clk); #1;
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_result", bus.result, 8'h7F);
            check("bp_flags", {bus.carry, bus.overflow, bus.zero}, 3'b110);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_idle", bus.in_ready, 1'b1);
        check("bp_release_ov", bus.out_valid, 1'b0);
        directed("bp_fresh", 1'b0, 8'h22, 8'h11, 8'h33, 1'b0, 1'b0, 1'b0);

        // Reset during RUN discards the operation and clears the outputs.
        bus.op = 1'b0;
        bus.a = 8'h7F;
        bus.b = 8'h01;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_result", bus.result, 8'h00);
        check("mid_rst_flags", {bus.carry, bus.overflow, bus.zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        directed("post_rst", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);

        // Back-to-back with both handshakes held high.
        accepts = 0;
        results = 0;
        last_acc = 0;
        bus.op = 1'($urandom_range(1));
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && results < 200; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("b2b_result", {bus.zero, bus.overflow, bus.carry, bus.result}, e);
                end else begin
                    check("b2b_unexpected", 1'b1, 1'b0);
                end
                results++;
            end
            acc = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(bus.op, bus.a, bus.b));
                if (accepts > 0) check("b2b_spacing", cyc - last_acc, W + 2);
                last_acc = cyc;
                accepts++;
                acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin
                bus.op = 1'($urandom_range(1));
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
                if (accepts >= 200) bus.in_valid = 1'b0;
            end
        end
        check("b2b_count", results, 200);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
